// File: rtl/game_pkg.sv
// Shared encodings for the game flow controller: external game-state codes,
// internal flow FSM states and saturating decrement helpers.
package game_pkg;

  // Game state as reported by the external game state machine
  typedef enum logic [1:0] {
    GAME_INITIAL = 2'b00,
    GAME_RUNNING = 2'b01,
    GAME_OVER    = 2'b10,
    GAME_SUCCESS = 2'b11
  } game_state_e;

  // Internal flow FSM states
  typedef enum logic [1:0] {
    FLOW_IDLE  = 2'b00,
    FLOW_PLAY  = 2'b01,
    FLOW_DYING = 2'b10,
    FLOW_DONE  = 2'b11
  } flow_state_e;

  localparam int LIVES_W = 3;
  localparam int TIME_W  = 9;

  // Lives counter never wraps below zero
  function automatic logic [LIVES_W-1:0] sat_dec_lives(input logic [LIVES_W-1:0] v);
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

  // Seconds counter never wraps below zero
  function automatic logic [TIME_W-1:0] sat_dec_time(input logic [TIME_W-1:0] v);
    return (v == 9'd0) ? 9'd0 : v - 9'd1;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Button conditioner: two-flop synchronizer for an asynchronous button level
// followed by a rising-edge detector. The rise output is valid two cycles after
// the raw edge; the consumer registers it, giving a three-cycle pulse latency.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // Synchronize the raw level and keep one cycle of history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign rise = sync2_r & ~prev_r;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game flow controller: conditions start/restart buttons, tracks lives,
// death freeze and game-over / success levels.
// Optional feature: define GAME_TIMER_EN to count time_left down once per
// FRAMES_PER_SEC frame ticks while playing; expiry ends the game.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int LIVES_INIT     = 3,
  parameter int TIME_INIT      = 300,
  parameter int FRAMES_PER_SEC = 60,
  parameter int DIE_FRAMES     = 90
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_start,
  input  logic       btn_restart,
  input  logic       hit,
  input  logic       fall,
  input  logic       goal,
  input  logic [1:0] game_state,
  output logic       start,
  output logic       restart,
  output logic       over,
  output logic       success,
  output logic       freeze,
  output logic       respawn,
  output logic [2:0] lives,
  output logic [8:0] time_left
);

  localparam int DIE_W = $clog2(DIE_FRAMES + 1);
  localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);
  localparam logic [TIME_W-1:0]  TIME_LOAD  = TIME_W'(TIME_INIT);
  localparam logic [DIE_W-1:0]   DIE_LOAD   = DIE_W'(DIE_FRAMES);

  logic start_rise_s;
  logic restart_rise_s;
  logic time_up_s;

  logic               start_r;
  logic               restart_r;
  flow_state_e        state_r;
  logic [DIE_W-1:0]   die_cnt_r;
  logic [LIVES_W-1:0] lives_r;
  logic [TIME_W-1:0]  time_left_r;
  logic               over_r;
  logic               success_r;
  logic               freeze_r;
  logic               respawn_r;

  btn_edge u_start_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_start),
    .rise  (start_rise_s)
  );

  btn_edge u_restart_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_restart),
    .rise  (restart_rise_s)
  );

  // Button pulses: restart always wins, start only from the title screen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_r   <= 1'b0;
      restart_r <= 1'b0;
    end else begin
      start_r   <= start_rise_s & ~restart_rise_s & (game_state == GAME_INITIAL);
      restart_r <= restart_rise_s;
    end
  end

`ifdef GAME_TIMER_EN
  localparam int FC_W = $clog2(FRAMES_PER_SEC + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_SEC - 1);

  logic [FC_W-1:0] frame_cnt_r;
  logic            sec_done_s;

  // A second elapses on the last frame of the second while playing
  always_comb begin
    sec_done_s = 1'b0;
    time_up_s  = 1'b0;
    if (frame_tick && (state_r == FLOW_PLAY) && (frame_cnt_r == FC_LAST)) begin
      sec_done_s = 1'b1;
      time_up_s  = (time_left_r <= 9'd1);
    end else begin
      sec_done_s = 1'b0;
      time_up_s  = 1'b0;
    end
  end

  // Frame-within-second counter, parked at zero outside of play start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_r <= '0;
    end else if (restart_r || (state_r == FLOW_IDLE)) begin
      frame_cnt_r <= '0;
    end else if ((state_r == FLOW_PLAY) && frame_tick) begin
      frame_cnt_r <= sec_done_s ? '0 : frame_cnt_r + FC_W'(1);
    end
  end
`else
  assign time_up_s = 1'b0;
`endif

  // Flow FSM with registered lives, time and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= FLOW_IDLE;
      die_cnt_r   <= '0;
      lives_r     <= LIVES_LOAD;
      time_left_r <= TIME_LOAD;
      over_r      <= 1'b0;
      success_r   <= 1'b0;
      freeze_r    <= 1'b1;
      respawn_r   <= 1'b0;
    end else begin
      respawn_r <= 1'b0;
      if (restart_r) begin
        state_r     <= FLOW_IDLE;
        die_cnt_r   <= '0;
        lives_r     <= LIVES_LOAD;
        time_left_r <= TIME_LOAD;
        over_r      <= 1'b0;
        success_r   <= 1'b0;
        freeze_r    <= 1'b0;
      end else begin
        case (state_r)
          FLOW_IDLE: begin
            if (start_r) begin
              state_r     <= FLOW_PLAY;
              die_cnt_r   <= '0;
              lives_r     <= LIVES_LOAD;
              time_left_r <= TIME_LOAD;
              freeze_r    <= 1'b0;
            end
          end
          FLOW_PLAY: begin
`ifdef GAME_TIMER_EN
            if (sec_done_s) begin
              time_left_r <= sat_dec_time(time_left_r);
            end
`endif
            if (time_up_s) begin
              state_r  <= FLOW_DONE;
              lives_r  <= 3'd0;
              over_r   <= 1'b1;
              freeze_r <= 1'b1;
            end else if (hit || fall) begin
              state_r   <= FLOW_DYING;
              freeze_r  <= 1'b1;
              die_cnt_r <= DIE_LOAD;
            end else if (goal) begin
              state_r   <= FLOW_DONE;
              success_r <= 1'b1;
              freeze_r  <= 1'b1;
            end
          end
          FLOW_DYING: begin
            if (frame_tick) begin
              if (die_cnt_r <= DIE_W'(1)) begin
                die_cnt_r <= '0;
                lives_r   <= sat_dec_lives(lives_r);
                if (lives_r <= 3'd1) begin
                  state_r <= FLOW_DONE;
                  over_r  <= 1'b1;
                end else begin
                  state_r   <= FLOW_PLAY;
                  respawn_r <= 1'b1;
                  freeze_r  <= 1'b0;
                end
              end else begin
                die_cnt_r <= die_cnt_r - DIE_W'(1);
              end
            end
          end
          FLOW_DONE: begin
            state_r <= FLOW_DONE;
          end
          default: begin
            state_r <= FLOW_IDLE;
          end
        endcase
      end
    end
  end

  assign start     = start_r;
  assign restart   = restart_r;
  assign over      = over_r;
  assign success   = success_r;
  assign freeze    = freeze_r;
  assign respawn   = respawn_r;
  assign lives     = lives_r;
  assign time_left = time_left_r;

endmodule

// File: tb/tb_game_flow_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for game_flow_ctrl: a game-rules model predicts every output
// event (start/restart/respawn pulses, over/success rises, snapshots) into a
// queue; a negedge monitor pops and compares whenever the DUT presents one.
module tb_game_flow_ctrl;

  localparam int LIVES_INIT = 3;
  localparam int DIE_FRAMES = 90;
`ifdef GAME_TIMER_EN
  localparam int TIME_INIT = 2;
  localparam int FPS       = 4;
`else
  localparam int TIME_INIT = 300;
  localparam int FPS       = 60;
`endif

  localparam int K_START   = 0;
  localparam int K_RESTART = 1;
  localparam int K_RESPAWN = 2;
  localparam int K_OVER    = 3;
  localparam int K_SUCCESS = 4;
  localparam int K_SNAP    = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_tick = 1'b0, btn_start = 1'b0, btn_restart = 1'b0;
  logic hit = 1'b0, fall = 1'b0, goal = 1'b0;
  logic [1:0] game_state = 2'b00;
  logic start, restart, over, success, freeze, respawn;
  logic [2:0] lives;
  logic [8:0] time_left;

  always #5 clk = ~clk;

  game_flow_ctrl #(
    .LIVES_INIT(LIVES_INIT), .TIME_INIT(TIME_INIT),
    .FRAMES_PER_SEC(FPS), .DIE_FRAMES(DIE_FRAMES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .btn_start(btn_start), .btn_restart(btn_restart),
    .hit(hit), .fall(fall), .goal(goal), .game_state(game_state),
    .start(start), .restart(restart), .over(over), .success(success),
    .freeze(freeze), .respawn(respawn), .lives(lives), .time_left(time_left)
  );

  typedef struct {
    int kind;
    int lv;
    int tl;
    bit frz;
    bit ovr;
    bit suc;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit snap_req = 1'b0;
  bit over_q = 1'b0, succ_q = 1'b0;

  // Game-rules model: phase 0 title, 1 playing, 2 dying, 3 finished
  int m_phase, m_lives, m_time, m_frame, m_die;
  bit m_freeze, m_over, m_succ;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_START:   return "start";
      K_RESTART: return "restart";
      K_RESPAWN: return "respawn";
      K_OVER:    return "over";
      K_SUCCESS: return "success";
      default:   return "snapshot";
    endcase
  endfunction

  function automatic void push(input int kind, input int c);
    exp_t e;
    e.kind = kind; e.lv = m_lives; e.tl = m_time;
    e.frz = m_freeze; e.ovr = m_over; e.suc = m_succ; e.cyc = c;
    sbq.push_back(e);
  endfunction

  function automatic void model_reset(input bit frz);
    m_phase = 0; m_lives = LIVES_INIT; m_time = TIME_INIT; m_frame = 0; m_die = 0;
    m_freeze = frz; m_over = 1'b0; m_succ = 1'b0;
  endfunction

  // The outside game state machine follows the flow: title, running, over, success
  task automatic set_gs();
    if (m_phase == 0)      game_state = 2'b00;
    else if (m_phase < 3)  game_state = 2'b01;
    else if (m_over)       game_state = 2'b10;
    else                   game_state = 2'b11;
  endtask

  task automatic observe(input int k);
    exp_t e;
    vectors++;
    if (sbq.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_%s at cycle %0d: got an event, required none", kname(k), cyc);
    end else begin
      e = sbq.pop_front();
      if (e.kind != k || int'(lives) != e.lv || int'(time_left) != e.tl || freeze != e.frz ||
          over != e.ovr || success != e.suc || (e.cyc >= 0 && e.cyc != cyc)) begin
        miscompares++;
        $display("FAIL %s: got %s lives=%0d time_left=%0d freeze=%0b over=%0b success=%0b cycle=%0d, required %s lives=%0d time_left=%0d freeze=%0b over=%0b success=%0b cycle=%0d",
                 kname(e.kind), kname(k), lives, time_left, freeze, over, success, cyc,
                 kname(e.kind), e.lv, e.tl, e.frz, e.ovr, e.suc, e.cyc);
      end
    end
  endtask

  // Monitor: any presented output event is matched against the scoreboard
  always @(negedge clk) begin
    if (start)               observe(K_START);
    if (restart)             observe(K_RESTART);
    if (respawn)             observe(K_RESPAWN);
    if (over && !over_q)     observe(K_OVER);
    if (success && !succ_q)  observe(K_SUCCESS);
    if (snap_req)            observe(K_SNAP);
    over_q <= over;
    succ_q <= success;
  end

  // Advance n rising edges and land 1ns after the last one
  task automatic step(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    push(K_SNAP, -1);
    snap_req = 1'b1;
    @(negedge clk);
    #1;
    snap_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input bit s, input bit r);
    int k;
    bit take_start;
    k = cyc;
    take_start = s && !r && (m_phase == 0);
    btn_start = s;
    btn_restart = r;
    if (r)               push(K_RESTART, k + 3);
    else if (take_start) push(K_START, k + 3);
    step(4);
    if (r) model_reset(1'b0);
    else if (take_start) begin
      m_phase = 1; m_freeze = 1'b0; m_frame = 0;
    end
    set_gs();
    step(2);
    btn_start = 1'b0;
    btn_restart = 1'b0;
    step(4);
  endtask

  task automatic poke(input bit h, input bit f, input bit g);
    int k;
    k = cyc;
    hit = h; fall = f; goal = g;
    if (m_phase == 1) begin
      if (h || f) begin
        m_phase = 2; m_freeze = 1'b1; m_die = DIE_FRAMES;
      end else if (g) begin
        m_phase = 3; m_succ = 1'b1; m_freeze = 1'b1;
        push(K_SUCCESS, k + 1);
      end
    end
    step(1);
    hit = 1'b0; fall = 1'b0; goal = 1'b0;
    set_gs();
    step(2);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int k;
      k = cyc;
      frame_tick = 1'b1;
      if (m_phase == 2) begin
        m_die = m_die - 1;
        if (m_die == 0) begin
          if (m_lives > 0) m_lives = m_lives - 1;
          if (m_lives == 0) begin
            m_phase = 3; m_over = 1'b1;
            push(K_OVER, k + 1);
          end else begin
            m_phase = 1; m_freeze = 1'b0;
            push(K_RESPAWN, k + 1);
          end
        end
      end else if (m_phase == 1) begin
`ifdef GAME_TIMER_EN
        m_frame = m_frame + 1;
        if (m_frame == FPS) begin
          m_frame = 0;
          if (m_time <= 1) begin
            m_time = 0; m_lives = 0; m_phase = 3; m_over = 1'b1; m_freeze = 1'b1;
            push(K_OVER, k + 1);
          end else begin
            m_time = m_time - 1;
          end
        end
`endif
      end
      step(1);
      frame_tick = 1'b0;
      set_gs();
      step(int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    model_reset(1'b1);
    set_gs();
    snap();                         // held in reset
    rst_n = 1'b1;
    step(2);
    snap();                         // idle after reset
    press(1'b1, 1'b0);              // start -> lives/time loaded
    snap();
    poke(1'b1, 1'b0, 1'b0);         // hit -> freeze
    ticks(89);
    snap();                         // still frozen one frame before the end
    ticks(1);                       // respawn, lives 2
    poke(1'b0, 1'b1, 1'b0);         // fall
    ticks(DIE_FRAMES);              // lives 1
    poke(1'b1, 1'b0, 1'b1);         // death beats goal
    snap();
    ticks(DIE_FRAMES);              // lives 0 -> over
    poke(1'b1, 1'b0, 1'b0);         // ignored once over
    ticks(5);
    snap();
    press(1'b1, 1'b0);              // no start outside the title screen
    press(1'b0, 1'b1);              // restart
    snap();
    press(1'b1, 1'b0);
    ticks(8);                       // timer build: runs out of time
    snap();
    press(1'b1, 1'b1);              // simultaneous -> restart only
    snap();

    repeat (60) begin
      case ($urandom_range(0, 9))
        0, 1:    press(1'b1, 1'b0);
        2:       press(1'b0, 1'b1);
        3:       press(1'b1, 1'b1);
        4:       poke(1'b1, 1'b0, 1'($urandom_range(0, 1)));
        5:       poke(1'b0, 1'b1, 1'b0);
        6:       poke(1'b0, 1'b0, 1'b1);
        7, 8:    ticks(int'($urandom_range(1, 100)));
        default: snap();
      endcase
    end

    press(1'b0, 1'b1);              // reset mid-dying
    press(1'b1, 1'b0);
    poke(1'b1, 1'b0, 1'b0);
    ticks(10);
    rst_n = 1'b0;
    model_reset(1'b1);
    set_gs();
    snap();                         // checked before any clock edge
    step(2);
    rst_n = 1'b1;
    step(DIE_FRAMES);
    snap();
    press(1'b1, 1'b0);
    snap();
    step(10);

    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_%s: got no event, required one at cycle %0d", kname(e.kind), e.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 SHALL have parameter LIVES_INIT, default 3, lives loaded at game start (1..7).
REQ-002 SHALL have parameter TIME_INIT, default 300, countdown seconds loaded at game start (1..511).
REQ-003 SHALL have parameter FRAMES_PER_SEC, default 60, frame_tick pulses per countdown second.
REQ-004 SHALL have parameter DIE_FRAMES, default 90, frames of freeze after a death.
REQ-005 SHALL have port clk  in  1  system clock, all logic on its rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port frame_tick  in  1  one-cycle pulse per video frame.
REQ-008 SHALL have port btn_start  in  1  raw asynchronous start button level.
REQ-009 SHALL have port btn_restart  in  1  raw asynchronous restart button level.
REQ-010 SHALL have port hit  in  1  enemy-collision pulse from the physics block.
REQ-011 SHALL have port fall  in  1  fell-into-pit pulse from the physics block.
REQ-012 SHALL have port goal  in  1  flag-reached level from the physics block.
REQ-013 SHALL have port game_state  in  2  current game state (INITIAL 00, RUNNING 01, OVER 10, SUCCESS 11).
REQ-014 SHALL have port start  out  1  one-cycle pulse to the game state machine.
REQ-015 SHALL have port restart  out  1  one-cycle pulse to the game state machine.
REQ-016 SHALL have port over  out  1  level, held until restart.
REQ-017 SHALL have port success  out  1  level, held until restart.
REQ-018 SHALL have port freeze  out  1  high while player motion is suspended.
REQ-019 SHALL have port respawn  out  1  one-cycle pulse: return player to checkpoint.
REQ-020 SHALL have port lives  out  3  remaining lives.
REQ-021 SHALL have port time_left  out  9  remaining seconds.

Function
REQ-022 SHALL pass each button through a 2-flop synchronizer and rising-edge detector; start/restart pulse 3 cycles after the raw rising edge.
REQ-023 SHALL emit start only when game_state==INITIAL; restart in any state; both same edge -> restart only.
REQ-024 SHALL run internal FSM IDLE, PLAY, DYING, DONE; IDLE->PLAY on start pulse, reloading lives=LIVES_INIT, time_left=TIME_INIT, frame counter=0.
REQ-025 SHALL in PLAY on hit or fall go to DYING, freeze=1, load die counter DIE_FRAMES.
REQ-026 SHALL in DYING decrement die counter per frame_tick; at zero decrement lives; lives now 0 -> DONE with over=1; else respawn pulse, freeze=0, PLAY.
REQ-027 SHALL in PLAY on goal (no hit/fall same cycle) go to DONE with success=1, freeze=1; death takes priority over goal.
REQ-028 SHALL ignore hit, fall, goal outside PLAY, including during DYING.
REQ-029 SHALL on restart pulse from any internal state go to IDLE, clear over/success/freeze, reload lives and time_left.
REQ-030 SHALL never underflow lives or time_left (saturate at 0).

Reset
REQ-031 SHALL on rst_n low immediately force IDLE, start=restart=over=success=respawn=0, freeze=1, lives=LIVES_INIT, time_left=TIME_INIT, all counters 0.
REQ-032 SHALL resume only on the first clk edge after rst_n deasserts; synchronizer flops reset to 0 so a held button does not pulse.

Configuration
REQ-033 SHALL with GAME_TIMER_EN defined decrement time_left every FRAMES_PER_SEC frame_ticks in PLAY only; reaching 0 acts as a death with lives forced to 0 (-> DONE, over=1).
REQ-034 SHALL without GAME_TIMER_EN hold time_left at TIME_INIT and omit the seconds counter.

Structure
REQ-035 SHALL place game state encodings (GAME_INITIAL..GAME_SUCCESS) and internal FSM encodings in shared package game_pkg.
REQ-036 SHALL instantiate sub-module btn_edge (synchronizer + rising-edge pulse) once per button.

Verification
REQ-037 SHALL check: reset, btn_start rise with game_state=00 -> start pulse 3 cycles later, lives=3, time_left=300.
REQ-038 SHALL check: hit in PLAY -> freeze=1 for 90 frame_ticks, then lives=2, one respawn pulse, freeze=0.
REQ-039 SHALL check: three deaths -> lives=0, over=1 held, further hit ignored.
REQ-040 SHALL check: goal and hit same cycle -> DYING, success stays 0.
REQ-041 SHALL check (GAME_TIMER_EN, TIME_INIT=2, FRAMES_PER_SEC=4): 8 frame_ticks -> time_left=0, over=1.
REQ-042 SHALL check: rst_n low mid-DYING -> outputs at reset values asynchronously, no respawn pulse.
